draw_character: RTL and testbench

DRAW_CHARACTER -- requirements
Module: draw_character

---
 rtl/draw_character_pkg.sv | 44 ++++
 rtl/character_rom.sv | 29 ++
 rtl/draw_character.sv | 141 ++++++++++++++
 tb/tb_draw_character.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/draw_character_pkg.sv
// draw_character_pkg
// Shared definitions for the character lane drawer and its eraser:
// FSM state encoding, lane base-X table, lane geometry defaults,
// the transparent colour code and the default sprite image.
package draw_character_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int unsigned CHAR_W_DEF = 9;
  localparam int unsigned CHAR_H_DEF = 5;
  localparam int unsigned Y_BASE_DEF = 102;

  localparam logic [2:0] TRANSPARENT = 3'b111;

  // Sprite image: 64 entries x 3 bits, entry n at bits [3n +: 3].
  localparam int unsigned ROM_DEPTH = 64;
  localparam int unsigned ROM_BITS  = 3 * ROM_DEPTH;

  function automatic logic [7:0] lane_base_x(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_base_x = 8'd6;
      2'd1:    lane_base_x = 8'd24;
      2'd2:    lane_base_x = 8'd78;
      default: lane_base_x = 8'd132;
    endcase
  endfunction

  // Default image: fully opaque 9x5 pattern, unused entries transparent.
  function automatic logic [ROM_BITS-1:0] make_default_sprite();
    logic [ROM_BITS-1:0] s;
    s = '1;
    for (int unsigned i = 0; i < CHAR_W_DEF * CHAR_H_DEF; i++) begin
      s[3*i +: 3] = 3'(i % 7);
    end
    return s;
  endfunction

  localparam logic [ROM_BITS-1:0] DEFAULT_SPRITE = make_default_sprite();

endpackage

// File: rtl/character_rom.sv
// character_rom
// Sprite colour storage with a registered read (one cycle latency).
// Ports:
//   Clock   - read clock
//   address - pixel index, row*CHAR_W + col
//   data    - 3-bit colour, valid the cycle after address is presented
module character_rom
  import draw_character_pkg::*;
#(
  parameter logic [ROM_BITS-1:0] CONTENTS = DEFAULT_SPRITE
) (
  input  logic       Clock,
  input  logic [5:0] address,
  output logic [2:0] data
);

  logic [2:0] mem [ROM_DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < ROM_DEPTH; i++) begin
      mem[i] = CONTENTS[3*i +: 3];
    end
  end

  always_ff @(posedge Clock) begin
    data <= mem[address];
  end

endmodule

// File: rtl/draw_character.sv
// draw_character
// Draws a CHAR_W x CHAR_H sprite into one of four lanes on the VGA
// adapter, one pixel per clock in row-major order.
// Ports:
//   Clock       - rising-edge clock
//   Reset       - synchronous active-high reset
//   Start       - draw request, honoured only when idle and not busy
//   Position    - lane index 0..3; larger values finish without drawing
//   XOut, YOut  - pixel coordinate
//   Color       - pixel colour
//   Plot        - write enable (low for transparent pixels)
//   Busy        - draw in progress, includes the DoneDrawing cycle
//   DoneDrawing - one-cycle completion pulse
module draw_character
  import draw_character_pkg::*;
#(
  parameter int unsigned          CHAR_W = CHAR_W_DEF,
  parameter int unsigned          CHAR_H = CHAR_H_DEF,
  parameter int unsigned          Y_BASE = Y_BASE_DEF,
  parameter logic [ROM_BITS-1:0]  SPRITE = DEFAULT_SPRITE
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Position,
  output logic [7:0] XOut,
  output logic [6:0] YOut,
  output logic [2:0] Color,
  output logic       Plot,
  output logic       Busy,
  output logic       DoneDrawing
);

  localparam logic [7:0] COL_LAST = 8'(CHAR_W - 1);
  localparam logic [6:0] ROW_LAST = 7'(CHAR_H - 1);

  state_t     state, state_n;
  logic [7:0] col;
  logic [6:0] row;
  logic [1:0] lane;
  logic       accept;
  logic       last_pix;
  logic [5:0] rom_addr;
  logic [2:0] rom_data;

  // Stage aligned with the registered ROM read.
  logic       s1_v;
  logic [7:0] s1_x;
  logic [6:0] s1_y;

  // Busy also covers the DoneDrawing cycle, so a Start that arrives while
  // the FSM already sits in IDLE during that cycle must still be refused.
  assign accept   = (state == S_IDLE) && Start && !Busy;
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign rom_addr = 6'(row) * 6'(CHAR_W) + 6'(col);

  character_rom #(
    .CONTENTS (SPRITE)
  ) u_rom (
    .Clock   (Clock),
    .address (rom_addr),
    .data    (rom_data)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // FINISH waits for the last pixel to leave the ROM stage so that
  // DoneDrawing lands one cycle after the last pixel on the outputs.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) state_n = (Position > 4'd3) ? S_FINISH : S_DRAW;
      end
      S_DRAW: begin
        if (last_pix) state_n = S_FINISH;
      end
      S_FINISH: begin
        if (!s1_v) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col  <= '0;
      row  <= '0;
      lane <= '0;
    end else if (accept) begin
      col  <= '0;
      row  <= '0;
      lane <= Position[1:0];
    end else if (state == S_DRAW) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 7'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
    end else begin
      s1_v <= (state == S_DRAW);
      s1_x <= lane_base_x(lane) + col;
      s1_y <= 7'(Y_BASE) + row;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      XOut        <= '0;
      YOut        <= '0;
      Color       <= '0;
      Plot        <= 1'b0;
      Busy        <= 1'b0;
      DoneDrawing <= 1'b0;
    end else begin
      Busy        <= s1_v || (state == S_FINISH);
      DoneDrawing <= (state == S_FINISH) && !s1_v;
      if (s1_v) begin
        XOut  <= s1_x;
        YOut  <= s1_y;
        Color <= rom_data;
        Plot  <= (rom_data != TRANSPARENT);
      end else begin
        Plot  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_draw_character.sv
module tb_draw_character;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [3:0] Position;
  logic [7:0] XOut;
  logic [6:0] YOut;
  logic [2:0] Color;
  logic       Plot;
  logic       Busy;
  logic       DoneDrawing;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned lane_x [4] = '{6, 24, 78, 132};

  // Reference sprite: one transparent pixel at col 4, row 2.
  function automatic logic [2:0] sprite_color(input int unsigned i);
    if (i == 22) return 3'b111;
    return 3'((i * 5 + 3) % 7);
  endfunction

  function automatic logic [191:0] build_sprite();
    logic [191:0] s;
    s = '1;
    for (int unsigned i = 0; i < 45; i++) s[3*i +: 3] = sprite_color(i);
    return s;
  endfunction

  localparam logic [191:0] TB_SPRITE = build_sprite();

  draw_character #(
    .CHAR_W (9),
    .CHAR_H (5),
    .Y_BASE (102),
    .SPRITE (TB_SPRITE)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Position    (Position),
    .XOut        (XOut),
    .YOut        (YOut),
    .Color       (Color),
    .Plot        (Plot),
    .Busy        (Busy),
    .DoneDrawing (DoneDrawing)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // mode 0: plain draw, 1: Start with Position=2 mid-draw, 2: Reset at pixel 20
  task automatic run_draw(input int unsigned pos, input int unsigned mode);
    int unsigned bx, nplot, nbusy, ex, ey;
    logic [2:0]  ec;
    bit          ok;
    ok    = (pos <= 3);
    bx    = ok ? lane_x[pos] : 0;
    nplot = 0;
    nbusy = 0;
    Start = 1'b1;
    Position = 4'(pos);
    tick();
    Start = 1'b0;
    Position = 4'($urandom_range(0, 15));
    chk("accept_busy", Busy, 0);
    chk("accept_done", DoneDrawing, 0);
    tick();
    if (!ok) begin
      chk("inv_done", DoneDrawing, 1);
      chk("inv_busy", Busy, 1);
      chk("inv_plot", Plot, 0);
      tick();
      chk("inv_done_end", DoneDrawing, 0);
      chk("inv_busy_end", Busy, 0);
      chk("inv_plot_end", Plot, 0);
      return;
    end
    chk("lat_plot", Plot, 0);
    chk("lat_busy", Busy, 0);
    chk("lat_done", DoneDrawing, 0);
    for (int unsigned i = 0; i < 45; i++) begin
      tick();
      ex = bx + (i % 9);
      ey = 102 + (i / 9);
      ec = sprite_color(i);
      chk("pix_x", XOut, ex);
      chk("pix_y", YOut, ey);
      chk("pix_plot", Plot, (ec != 3'b111) ? 1 : 0);
      if (ec != 3'b111) chk("pix_color", Color, ec);
      chk("pix_busy", Busy, 1);
      chk("pix_done", DoneDrawing, 0);
      nplot += Plot;
      nbusy += Busy;
      if (mode == 1 && i == 10) begin
        Start = 1'b1;
        Position = 4'd2;
      end
      if (mode == 1 && i == 13) Start = 1'b0;
      if (mode == 2 && i == 20) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_x", XOut, 0);
        chk("rst_y", YOut, 0);
        chk("rst_color", Color, 0);
        chk("rst_plot", Plot, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", DoneDrawing, 0);
        for (int unsigned j = 0; j < 40; j++) begin
          tick();
          chk("abort_plot", Plot, 0);
          chk("abort_done", DoneDrawing, 0);
          chk("abort_busy", Busy, 0);
        end
        return;
      end
    end
    tick();
    chk("fin_done", DoneDrawing, 1);
    chk("fin_busy", Busy, 1);
    chk("fin_plot", Plot, 0);
    nbusy += Busy;
    tick();
    chk("idle_done", DoneDrawing, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_plot", Plot, 0);
    chk("plot_count", nplot, 44);
    chk("busy_cycles", nbusy, 46);
  endtask

  initial begin
    // Reset wins over a simultaneous Start.
    Reset = 1'b1;
    Start = 1'b1;
    Position = 4'd0;
    tick();
    tick();
    chk("reset_x", XOut, 0);
    chk("reset_y", YOut, 0);
    chk("reset_color", Color, 0);
    chk("reset_plot", Plot, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", DoneDrawing, 0);
    Reset = 1'b0;
    Start = 1'b0;
    tick();
    tick();
    chk("post_reset_busy", Busy, 0);
    chk("post_reset_plot", Plot, 0);

    run_draw(0, 0);          // lane 0, (6,102)..(14,106)
    run_draw(3, 0);          // lane 3, last pixel (140,106), back-to-back
    run_draw(1, 0);          // transparent pixel at (28,104)
    run_draw(5, 0);          // invalid lane
    run_draw(2, 0);
    run_draw(0, 1);          // mid-draw Start ignored
    run_draw(0, 2);          // reset aborts draw
    for (int unsigned k = 0; k < 8; k++) begin
      run_draw($urandom_range(0, 7), 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
